// File: rtl/output_stream_packer.sv
// output_stream_packer: small result buffer that packs core output words into
// AXI-Stream packets of cfg_beats beats, closing a packet early when a word
// carries the end-of-result flag (bit DATA_WIDTH_FIFO_OUT).
// Optional feature: define PACKER_OVERFLOW_CNT_EN to add the overflow_cnt
// output counting pushes dropped while the buffer is full.
module output_stream_packer #(
    parameter int DATA_WIDTH_FIFO_OUT = 64,
    parameter int DEPTH               = 8,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [DATA_WIDTH_FIFO_OUT:0]   outfifo_din,
    input  logic                           outfifo_write,
    output logic                           outfifo_is_full,
    input  logic [CNT_WIDTH-1:0]           cfg_beats,
    output logic [DATA_WIDTH_FIFO_OUT-1:0] m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [$clog2(DEPTH):0]         level,
    output logic                           pkt_done,
    output logic                           idle
`ifdef PACKER_OVERFLOW_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]           overflow_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [DATA_WIDTH_FIFO_OUT:0] mem [DEPTH];
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic                         push;
    logic                         pop;
    logic                         head_flag;

    state_t                       state_q, state_d;
    logic [CNT_WIDTH-1:0]         beats_q, beats_d;
    logic [CNT_WIDTH-1:0]         beat_cnt, beat_cnt_d;
    logic [CNT_WIDTH-1:0]         beats_cfg;
    logic [CNT_WIDTH-1:0]         beats_cur;
    logic                         pkt_done_d;

    // Full depends only on the registered level, so a push into a full
    // buffer is dropped even when a pop happens in the same cycle.
    assign outfifo_is_full = (level == LW'(DEPTH));
    assign push            = outfifo_write && !outfifo_is_full;
    assign m_axis_tvalid   = enable && (level != '0);
    assign pop             = m_axis_tvalid && m_axis_tready;

    assign m_axis_tdata    = mem[rd_ptr][DATA_WIDTH_FIFO_OUT-1:0];
    assign head_flag       = mem[rd_ptr][DATA_WIDTH_FIFO_OUT];

    // A zero beat count is treated as single-beat packets; in IDLE the packet
    // length follows the live configuration until the first beat is taken.
    assign beats_cfg       = (cfg_beats == '0) ? CNT_WIDTH'(1) : cfg_beats;
    assign beats_cur       = (state_q == IDLE) ? beats_cfg : beats_q;
    assign m_axis_tlast    = m_axis_tvalid &&
                             ((beat_cnt == beats_cur - CNT_WIDTH'(1)) || head_flag);

    assign idle            = (state_q == IDLE) && (level == '0);

    // Buffer storage: written on accepted pushes only.
    // NOTE: storage is deliberately not reset; pointers and level alone decide
    // which entries are valid, so clearing the array would only cost area.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= outfifo_din;
        end
    end

    // Pointers wrap naturally modulo DEPTH; level tracks occupancy.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Packet FSM next-state: latch length on the first beat, count beats,
    // close on tlast and flag completion for the following cycle.
    // NOTE: every signal gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        beats_d    = beats_q;
        beat_cnt_d = beat_cnt;
        pkt_done_d = 1'b0;
        if (pop) begin
            if (state_q == IDLE) begin
                beats_d = beats_cfg;
            end
            if (m_axis_tlast) begin
                state_d    = IDLE;
                beat_cnt_d = '0;
                pkt_done_d = 1'b1;
            end else begin
                state_d    = ACTIVE;
                beat_cnt_d = beat_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Packet FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            beats_q  <= '0;
            beat_cnt <= '0;
            pkt_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            beats_q  <= beats_d;
            beat_cnt <= beat_cnt_d;
            pkt_done <= pkt_done_d;
        end
    end

`ifdef PACKER_OVERFLOW_CNT_EN
    // Saturating count of pushes dropped because the buffer was full.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_cnt <= '0;
        end else if (outfifo_write && outfifo_is_full && (overflow_cnt != '1)) begin
            overflow_cnt <= overflow_cnt + CNT_WIDTH'(1);
        end
    end
`else
    // Overflow accounting not built in this configuration.
`endif

endmodule

// File: doc/output_stream_packer.md
OUTPUT_STREAM_PACKER -- requirements
Module: output_stream_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH_FIFO_OUT, default 64, the result word width without flag.
REQ-002 SHALL have parameter DEPTH, default 8 (power of 2), the number of buffer entries.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, the width of the beat counter and event counter.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port reset  input  1  synchronous reset, active high.
REQ-006 SHALL have port enable  input  1  drain enable; when low, tvalid is forced 0 and pushes are still accepted.
REQ-007 SHALL have port outfifo_din  input  DATA_WIDTH_FIFO_OUT+1  result word from the core; bit [DATA_WIDTH_FIFO_OUT] is the end-of-result flag.
REQ-008 SHALL have port outfifo_write  input  1  push strobe from the core.
REQ-009 SHALL have port outfifo_is_full  output  1  back-pressure to the core, high when count==DEPTH.
REQ-010 SHALL have port cfg_beats  input  CNT_WIDTH  beats per packet, latched at packet start.
REQ-011 SHALL have port m_axis_tdata  output  DATA_WIDTH_FIFO_OUT  head word, bits [DATA_WIDTH_FIFO_OUT-1:0].
REQ-012 SHALL have port m_axis_tvalid  output  1  head valid.
REQ-013 SHALL have port m_axis_tready  input  1  downstream accept.
REQ-014 SHALL have port m_axis_tlast  output  1  last beat of packet.
REQ-015 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 SHALL have port pkt_done  output  1  one-cycle pulse after each tlast handshake.
REQ-017 SHALL have port idle  output  1  high in state IDLE with level==0.

Function
REQ-018 SHALL push when outfifo_write && !outfifo_is_full, so the word is visible at the head one cycle later at the earliest.
REQ-019 SHALL pop when m_axis_tvalid && m_axis_tready.
REQ-020 SHALL drive m_axis_tvalid = enable && (level!=0), and m_axis_tdata from the head entry.
REQ-021 SHALL, on simultaneous push and pop with 0<level<DEPTH, leave level unchanged and process both.
REQ-022 SHALL, with level==DEPTH, drop a push even if a pop occurs in the same cycle, because outfifo_is_full is a function of the registered count only.
REQ-023 SHALL wrap read and write pointers modulo DEPTH.
REQ-024 SHALL implement an FSM with states IDLE and ACTIVE.
REQ-025 SHALL, in IDLE, on the first handshake latch cfg_beats into beats_q (0 treated as 1), clear beat_cnt, and go to ACTIVE unless that beat is tlast.
REQ-026 SHALL assert m_axis_tlast = (beat_cnt==beats_q-1) || head flag bit; in IDLE, beats_q is taken from the live cfg_beats.
REQ-027 SHALL, on a tlast handshake, clear beat_cnt, return to IDLE, and assert pkt_done in the next cycle.
REQ-028 SHALL, on a non-last handshake in ACTIVE, increment beat_cnt by 1.
REQ-029 SHALL ignore cfg_beats changes while ACTIVE.
REQ-030 SHALL hold tdata and tlast stable while tvalid && !tready.

Reset
REQ-031 SHALL, when reset is high at a clk edge, clear pointers, level, beat_cnt, beats_q, pkt_done and the event counter, and set the FSM to IDLE.
REQ-032 SHALL, after reset, present outputs tvalid=0, tlast=0, outfifo_is_full=0, idle=1, pkt_done=0, level=0.
REQ-033 SHALL discard buffered data on reset mid-packet; the next beat starts a new packet.

Configuration
REQ-034 SHALL, with macro PACKER_OVERFLOW_CNT_EN defined, add output overflow_cnt [CNT_WIDTH-1:0], which counts dropped pushes (outfifo_write while full), saturates at all-ones, and is cleared by reset.
REQ-035 SHALL, without PACKER_OVERFLOW_CNT_EN, omit the overflow_cnt port and its logic; all other behaviour is identical.

Verification
REQ-036 SHALL verify: cfg_beats=3, push 0xA,0xB,0xC, tready=1 -> beats A,B,C on consecutive cycles; tlast only on C; pkt_done one cycle after C; idle=1 after.
REQ-037 SHALL verify: DEPTH=8, tready=0, 9 pushes -> level=8, outfifo_is_full=1 after the 8th push; 9th dropped; overflow_cnt=1 when the macro is defined.
REQ-038 SHALL verify: cfg_beats=4, 2nd word has flag bit set -> tlast on beat 2; the next packet re-latches cfg_beats.
REQ-039 SHALL verify: tready toggling 1,0,1,0 with level=4 -> tdata/tlast stable during stalls; order is preserved across pointer wrap after 12 pushes.
REQ-040 SHALL verify: enable=0 with 3 words buffered -> tvalid=0, level=3; after enable=1, 3 beats drain.
REQ-041 SHALL verify: reset asserted after beat 1 of a 3-beat packet -> level=0, idle=1; the next push produces beat_cnt=0 with a freshly latched cfg_beats.
